// File: rtl/vc_arbiter_if.sv
// vc_arbiter_if: bundle of the VC-FIFO side, destination-FIFO side and status
// signals of the virtual-channel arbiter. The arbiter attaches through the
// master modport. The surrounding FIFOs, or a bench, attach through slave.
interface vc_arbiter_if #(
  parameter int DATA_SIZE = 6
);
  // VC FIFO side
  logic                 fifo_empty_vc0;
  logic                 fifo_empty_vc1;
  logic [DATA_SIZE-1:0] data_vc0;
  logic [DATA_SIZE-1:0] data_vc1;
  logic                 pop_vc0;
  logic                 pop_vc1;

  // Destination FIFO side
  logic                 fifo_pause_d0;
  logic                 fifo_pause_d1;
  logic                 push_d0;
  logic                 push_d1;
  logic [DATA_SIZE-1:0] data_d0;
  logic [DATA_SIZE-1:0] data_d1;

  // Status / debug
  logic [1:0]           arb_state;
  logic [3:0]           burst_cnt;

  modport master (
    input  fifo_empty_vc0, fifo_empty_vc1, data_vc0, data_vc1,
    input  fifo_pause_d0, fifo_pause_d1,
    output pop_vc0, pop_vc1,
    output push_d0, push_d1, data_d0, data_d1,
    output arb_state, burst_cnt
  );

  modport slave (
    output fifo_empty_vc0, fifo_empty_vc1, data_vc0, data_vc1,
    output fifo_pause_d0, fifo_pause_d1,
    input  pop_vc0, pop_vc1,
    input  push_d0, push_d1, data_d0, data_d1,
    input  arb_state, burst_cnt
  );
endinterface

// File: rtl/vc_arbiter.sv
// vc_arbiter: weighted-priority scheduler from two virtual-channel FIFOs to
// two destination FIFOs.
// - vc0 is preferred. After VC0_WEIGHT back-to-back vc0 grants while vc1 is
//   waiting, vc1 gets one slot.
// - A popped word is read one cycle later and pushed the cycle after that.
//   Bit DEST_BIT of the word picks the destination.
// - Either destination pausing blocks new pops. Words already in flight
//   still drain.
module vc_arbiter #(
  parameter int DATA_SIZE  = 6,
  parameter int DEST_BIT   = 4,
  parameter int VC0_WEIGHT = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  vc_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT0  = 2'd1,
    ST_GNT1  = 2'd2,
    ST_PAUSE = 2'd3
  } arb_state_t;

  localparam logic [3:0] WEIGHT_C = 4'(VC0_WEIGHT);

  // Grant / stall
  logic                 pause_any_s;
  logic                 vc1_due_s;
  logic                 pop_vc0_s;
  logic                 pop_vc1_s;

  // Burst counter
  logic [3:0]           burst_cnt_r;
  logic [3:0]           burst_cnt_nxt_s;

  // FSM
  arb_state_t           state_r;
  arb_state_t           state_nxt_s;

  // Pending stage (word popped last cycle, data now on data_vcX)
  logic                 pend_v_r;
  logic                 pend_src_r;

  // Output stage
  logic [DATA_SIZE-1:0] sel_data_s;
  logic                 push_d0_r;
  logic                 push_d1_r;
  logic [DATA_SIZE-1:0] data_d0_r;
  logic [DATA_SIZE-1:0] data_d1_r;
  logic                 push_d0_nxt_s;
  logic                 push_d1_nxt_s;
  logic [DATA_SIZE-1:0] data_d0_nxt_s;
  logic [DATA_SIZE-1:0] data_d1_nxt_s;

  // The destination of a word is unknown until it is read, so a pause on
  // either destination has to block every pop.
  assign pause_any_s = bus.fifo_pause_d0 | bus.fifo_pause_d1;
  assign vc1_due_s   = (burst_cnt_r == WEIGHT_C);

  // Grant selection: vc0 first unless vc1 has waited through a full burst.
  always_comb begin
    pop_vc0_s = 1'b0;
    pop_vc1_s = 1'b0;
    if (!reset_L || pause_any_s) begin
      pop_vc0_s = 1'b0;
      pop_vc1_s = 1'b0;
    end else if (!bus.fifo_empty_vc0 && !bus.fifo_empty_vc1) begin
      if (vc1_due_s) begin
        pop_vc1_s = 1'b1;
      end else begin
        pop_vc0_s = 1'b1;
      end
    end else if (!bus.fifo_empty_vc0) begin
      pop_vc0_s = 1'b1;
    end else if (!bus.fifo_empty_vc1) begin
      pop_vc1_s = 1'b1;
    end else begin
      pop_vc0_s = 1'b0;
      pop_vc1_s = 1'b0;
    end
  end

  // Burst count: vc0 grants taken while vc1 waits, saturating at the weight.
  always_comb begin
    burst_cnt_nxt_s = burst_cnt_r;
    if (bus.fifo_empty_vc1 || pop_vc1_s) begin
      burst_cnt_nxt_s = 4'd0;
    end else if (pop_vc0_s && !vc1_due_s) begin
      burst_cnt_nxt_s = burst_cnt_r + 4'd1;
    end else begin
      burst_cnt_nxt_s = burst_cnt_r;
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      burst_cnt_r <= 4'd0;
    end else begin
      burst_cnt_r <= burst_cnt_nxt_s;
    end
  end

  // FSM next state: a status view of this cycle's grant decision.
  always_comb begin
    state_nxt_s = ST_IDLE;
    if (pause_any_s) begin
      state_nxt_s = ST_PAUSE;
    end else if (pop_vc0_s) begin
      state_nxt_s = ST_GNT0;
    end else if (pop_vc1_s) begin
      state_nxt_s = ST_GNT1;
    end else begin
      state_nxt_s = ST_IDLE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pending stage: remembers a pop until its data arrives from the VC FIFO.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pend_v_r   <= 1'b0;
      pend_src_r <= 1'b0;
    end else begin
      pend_v_r   <= pop_vc0_s | pop_vc1_s;
      pend_src_r <= pop_vc1_s;
    end
  end

  assign sel_data_s = pend_src_r ? bus.data_vc1 : bus.data_vc0;

  // Output routing: steer the pending word by its destination bit.
  // The data registers hold their value between pushes.
  always_comb begin
    push_d0_nxt_s = 1'b0;
    push_d1_nxt_s = 1'b0;
    data_d0_nxt_s = data_d0_r;
    data_d1_nxt_s = data_d1_r;
    if (pend_v_r) begin
      if (sel_data_s[DEST_BIT]) begin
        push_d1_nxt_s = 1'b1;
        data_d1_nxt_s = sel_data_s;
      end else begin
        push_d0_nxt_s = 1'b1;
        data_d0_nxt_s = sel_data_s;
      end
    end else begin
      push_d0_nxt_s = 1'b0;
      push_d1_nxt_s = 1'b0;
    end
  end

  // Output registers. Reset drops any word still in flight.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      push_d0_r <= 1'b0;
      push_d1_r <= 1'b0;
      data_d0_r <= '0;
      data_d1_r <= '0;
    end else begin
      push_d0_r <= push_d0_nxt_s;
      push_d1_r <= push_d1_nxt_s;
      data_d0_r <= data_d0_nxt_s;
      data_d1_r <= data_d1_nxt_s;
    end
  end

  assign bus.pop_vc0   = pop_vc0_s;
  assign bus.pop_vc1   = pop_vc1_s;
  assign bus.push_d0   = push_d0_r;
  assign bus.push_d1   = push_d1_r;
  assign bus.data_d0   = data_d0_r;
  assign bus.data_d1   = data_d1_r;
  assign bus.arb_state = state_r;
  assign bus.burst_cnt = burst_cnt_r;

endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: randomized and directed stimulus for vc_arbiter.
// - A reference model of the grant rules decides which VC must be popped
//   each cycle, and queues the expected destination push.
// - A monitor on the falling edge pops that queue and compares it with what
//   the DUT pushes.
module tb_vc_arbiter;
  localparam int DS = 6;
  localparam int DB = 4;
  localparam int W  = 4;

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  vc_arbiter_if #(.DATA_SIZE(DS)) bus();

  vc_arbiter #(.DATA_SIZE(DS), .DEST_BIT(DB), .VC0_WEIGHT(W)) dut (
    .clk(clk),
    .reset_L(reset_L),
    .bus(bus)
  );

  typedef struct {
    logic          dest;
    logic [DS-1:0] data;
    int            due;
  } exp_t;

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic [DS-1:0] q0[$];
  logic [DS-1:0] q1[$];
  exp_t          sb[$];
  logic [1:0]    exp_state;
  logic [3:0]    exp_burst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model + VC FIFO model.
  // - vc1 is owed a slot once W vc0 grants in a row went by while vc1 waited.
  // - The model's FIFOs present read data and empty flags 1 ns after the edge.
  initial begin : ref_model
    int            streak;
    int            g;
    logic          rs, pa, e0, e1, p0, p1;
    logic [DS-1:0] w;
    streak = 0;
    bus.fifo_empty_vc0 = 1'b1;
    bus.fifo_empty_vc1 = 1'b1;
    bus.data_vc0 = '0;
    bus.data_vc1 = '0;
    exp_state = 2'd0;
    exp_burst = 4'd0;
    forever begin
      @(posedge clk);
      p0 = bus.pop_vc0;
      p1 = bus.pop_vc1;
      e0 = bus.fifo_empty_vc0;
      e1 = bus.fifo_empty_vc1;
      pa = bus.fifo_pause_d0 | bus.fifo_pause_d1;
      rs = reset_L;
      cyc++;
      g = 0;
      if (rs && !pa) begin
        if (!e0 && (e1 || streak < W)) g = 1;
        else if (!e1) g = 2;
      end
      check("pop_vc0", {31'd0, p0}, {31'd0, (g == 1)});
      check("pop_vc1", {31'd0, p1}, {31'd0, (g == 2)});
      if (!rs || e1 || g == 2) streak = 0;
      else if (g == 1 && streak < W) streak++;
      exp_burst = 4'(streak);
      exp_state = !rs ? 2'd0 : pa ? 2'd3 : (g == 1) ? 2'd1 : (g == 2) ? 2'd2 : 2'd0;
      w = '0;
      if (g == 1) w = q0.pop_front();
      if (g == 2) w = q1.pop_front();
      if (g != 0) sb.push_back('{dest: w[DB], data: w, due: cyc + 1});
      #1;
      if (g == 1) bus.data_vc0 = w;
      if (g == 2) bus.data_vc1 = w;
      bus.fifo_empty_vc0 = (q0.size() == 0);
      bus.fifo_empty_vc1 = (q1.size() == 0);
    end
  end

  // Monitor: compare pushes, held data and status against the expectations.
  initial begin : monitor
    exp_t          e;
    logic [DS-1:0] last_d0;
    logic [DS-1:0] last_d1;
    last_d0 = '0;
    last_d1 = '0;
    forever begin
      @(negedge clk);
      if (!reset_L) begin
        sb.delete();
        last_d0 = '0;
        last_d1 = '0;
        check("rst_push", {30'd0, bus.push_d1, bus.push_d0}, 32'd0);
        check("rst_data", {20'd0, bus.data_d1, bus.data_d0}, 32'd0);
        check("rst_state", {30'd0, bus.arb_state}, 32'd0);
      end else begin
        check("arb_state", {30'd0, bus.arb_state}, {30'd0, exp_state});
        check("burst_cnt", {28'd0, bus.burst_cnt}, {28'd0, exp_burst});
        if (bus.push_d0 | bus.push_d1) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_push: got d0=%0b d1=%0b expected none (cycle %0d)",
                     bus.push_d0, bus.push_d1, cyc);
          end else begin
            e = sb.pop_front();
            check("push_d0", {31'd0, bus.push_d0}, {31'd0, !e.dest});
            check("push_d1", {31'd0, bus.push_d1}, {31'd0, e.dest});
            check("push_data", {26'd0, (e.dest ? bus.data_d1 : bus.data_d0)}, {26'd0, e.data});
            check("push_latency", cyc, e.due);
            if (e.dest) last_d1 = e.data;
            else last_d0 = e.data;
          end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          total++;
          bad++;
          $display("FAIL missing_push: got none expected data %0h (cycle %0d)", e.data, cyc);
        end
        if (!bus.push_d0) check("hold_d0", {26'd0, bus.data_d0}, {26'd0, last_d0});
        if (!bus.push_d1) check("hold_d1", {26'd0, bus.data_d1}, {26'd0, last_d1});
      end
    end
  end

  task automatic wait_idle(input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #3;
      if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0 &&
          bus.fifo_empty_vc0 && bus.fifo_empty_vc1) begin
        ok = 1;
        break;
      end
    end
    check("drain_timeout", ok, 1);
    repeat (3) @(posedge clk);
    #3;
  endtask

  // Stimulus
  initial begin : stim
    int seen;
    reset_L = 1'b0;
    bus.fifo_pause_d0 = 1'b0;
    bus.fifo_pause_d1 = 1'b0;
    #1;
    check("rst_pop", {30'd0, bus.pop_vc1, bus.pop_vc0}, 32'd0);
    check("rst_burst", {28'd0, bus.burst_cnt}, 32'd0);
    check("rst_push0", {30'd0, bus.push_d1, bus.push_d0}, 32'd0);

    // Three vc0 words for d0
    q0.push_back(6'h01);
    q0.push_back(6'h02);
    q0.push_back(6'h03);
    repeat (2) @(posedge clk);
    #2 reset_L = 1'b1;
    wait_idle(50);

    // Both VCs with 10 words: weighted interleave
    for (int i = 0; i < 10; i++) begin
      q0.push_back(6'($urandom_range(0, 63)));
      q1.push_back(6'($urandom_range(0, 63)));
    end
    wait_idle(100);

    // Pause for 5 cycles while streaming
    for (int i = 0; i < 12; i++) q0.push_back(6'($urandom_range(0, 63)));
    repeat (4) @(posedge clk);
    #2 bus.fifo_pause_d1 = 1'b1;
    repeat (5) @(posedge clk);
    #2 bus.fifo_pause_d1 = 1'b0;
    wait_idle(100);

    // vc1 word routed to d1
    q1.push_back(6'h10);
    wait_idle(50);

    // Reset in the cycle after a pop drops the word
    q0.push_back(6'h05);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.pop_vc0) seen = 1;
    end
    check("reset_pop_seen", seen, 1);
    @(posedge clk);
    #3 reset_L = 1'b0;
    #1;
    check("midrst_push", {30'd0, bus.push_d1, bus.push_d0}, 32'd0);
    check("midrst_data", {20'd0, bus.data_d1, bus.data_d0}, 32'd0);
    check("midrst_state", {30'd0, bus.arb_state}, 32'd0);
    check("midrst_pop", {30'd0, bus.pop_vc1, bus.pop_vc0}, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset_L = 1'b1;
    repeat (4) @(posedge clk);

    // Both empty: idle
    @(negedge clk);
    check("idle_pop", {30'd0, bus.pop_vc1, bus.pop_vc0}, 32'd0);
    check("idle_state", {30'd0, bus.arb_state}, 32'd0);
    check("idle_burst", {28'd0, bus.burst_cnt}, 32'd0);

    // Randomized traffic with random pauses
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 3) == 0) q0.push_back(6'($urandom_range(0, 63)));
      if ($urandom_range(0, 3) == 0) q1.push_back(6'($urandom_range(0, 63)));
      bus.fifo_pause_d0 = ($urandom_range(0, 9) == 0);
      bus.fifo_pause_d1 = ($urandom_range(0, 9) == 0);
    end
    @(posedge clk);
    #2;
    bus.fifo_pause_d0 = 1'b0;
    bus.fifo_pause_d1 = 1'b0;
    wait_idle(1000);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
